// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO family.
package fifo_pkg;

   // Read-side presentation mode
   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   localparam int FIFO_DATA_WIDTH_DEF = 8;
   localparam int FIFO_ADDR_WIDTH_DEF = 4;

   // The level counter needs one extra bit so that DEPTH itself is representable.
   function automatic int level_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset on contents.
module fifo_dp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

   // Write the addressed word on an accepted write
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, programmable almost flags,
// sticky overflow/underflow, synchronous flush and optional first-word-fall-through.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
   parameter int AF_THRESH  = 12,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wr_cs,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_cs,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int         DEPTH = 1 << ADDR_WIDTH;
   localparam int         LVL_W = level_width(ADDR_WIDTH);
   localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESH);
   localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_THRESH);

   // Reject out-of-range configuration at elaboration
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_range_chk
      $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_range_chk
      $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_fwft_chk
      $error("sync_fifo_param: FWFT must be 0 or 1");
   end

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [LVL_W-1:0]      r_level;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_wr_req;
   logic                  w_rd_req;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_full;
   logic                  w_empty;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign w_wr_req = wr_cs & wr_en;
   assign w_rd_req = rd_cs & rd_en;
   assign w_full   = (r_level == DEPTH_L);
   assign w_empty  = (r_level == '0);

   // A flush suppresses both ports for the cycle. At full, a concurrent read frees the slot
   // the write needs; at empty there is no bypass, so only the write lands.
   assign w_rd_acc = w_rd_req & ~w_empty & ~clr;
   assign w_wr_acc = w_wr_req & (~w_full | w_rd_acc) & ~clr;

   fifo_dp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (data_in),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // Pointers wrap naturally at DEPTH; flush returns both to the origin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Fill level: net change of one only when exactly one side is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
      end else if (clr) begin
         r_level <= '0;
      end else begin
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Sticky error flags, set by rejected requests and cleared only by flush or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (clr) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_req && !w_wr_acc) r_overflow  <= 1'b1;
         if (w_rd_req && !w_rd_acc) r_underflow <= 1'b1;
      end
   end

   if (MODE == FIFO_STD) begin : g_std
      logic [DATA_WIDTH-1:0] r_data_out;

      // Registered read: capture the head word on an accepted read, hold otherwise
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_data_out <= '0;
         end else if (w_rd_acc) begin
            r_data_out <= w_rd_data;
         end
      end

      assign data_out = r_data_out;
   end else begin : g_fwft
      // Head word shown directly; forced to zero while empty so uninitialised storage never leaks
      assign data_out = w_empty ? '0 : w_rd_data;
   end

   assign level        = r_level;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_level >= AF_L);
   assign almost_empty = (r_level <= AE_L);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule
